// File: rtl/dbus_responder.sv
// dbus_responder: DBUS slave with word RAM, programmable wait states and illegal-access flagging
//   i_Clk/i_Rstn           clock, synchronous active-low reset
//   i_dMEM_ReadEn/WriteEn  load/store request
//   i_dMEM_Addr            byte address
//   i_dMEM_Data_write      store data
//   o_dMEM_Data_read       registered load data
//   o_Busy                 stall request while an access is in flight
//   o_Done/o_Error         one-cycle completion pulse / illegal-access pulse
module dbus_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rstn,
  input  logic              i_dMEM_ReadEn,
  input  logic              i_dMEM_WriteEn,
  input  logic [ADDR_W-1:0] i_dMEM_Addr,
  input  logic [DATA_W-1:0] i_dMEM_Data_write,
  output logic [DATA_W-1:0] o_dMEM_Data_read,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Error
);
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH * 4);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  logic [1:0]        r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic              r_re, r_we, r_err, w_re, w_we, w_req, w_err, w_commit;
  logic [DATA_W-1:0] r_ram [DEPTH];
  assign w_req = i_dMEM_ReadEn | i_dMEM_WriteEn;
  // In IDLE the live bus is used so a zero-wait access commits on its accept edge
  assign w_addr  = r_state == S_IDLE ? i_dMEM_Addr       : r_addr;
  assign w_wdata = r_state == S_IDLE ? i_dMEM_Data_write : r_wdata;
  assign w_re    = r_state == S_IDLE ? i_dMEM_ReadEn     : r_re;
  assign w_we    = r_state == S_IDLE ? i_dMEM_WriteEn    : r_we;
  assign w_err   = (|w_addr[1:0]) | (w_addr >= LIM) | (w_re & w_we);
  // Commit only on the edge that enters RESP, and never while reset is asserted
  assign w_commit = i_Rstn & (w_next == S_RESP) & (r_state != S_RESP);
  always_ff @(posedge i_Clk)
    r_state <= !i_Rstn ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state == S_IDLE ? (w_req ? (WAIT_STATES > 0 ? S_WAIT : S_RESP) : S_IDLE)
           : r_state == S_WAIT ? (r_cnt == '0 ? S_RESP : S_WAIT)
           : S_IDLE;
  end
  always_comb begin
    o_Busy  = (r_state == S_IDLE && w_req) || r_state == S_WAIT;
    o_Done  = r_state == S_RESP;
    o_Error = (r_state == S_RESP) && r_err;
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) begin
      r_cnt            <= '0;
      r_err            <= 1'b0;
      o_dMEM_Data_read <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= i_dMEM_Addr;
        r_wdata <= i_dMEM_Data_write;
        r_re    <= i_dMEM_ReadEn;
        r_we    <= i_dMEM_WriteEn;
        r_cnt   <= CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
      end else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (w_commit)
        r_err <= w_err;
      if (w_commit && w_re)
        o_dMEM_Data_read <= w_err ? '0 : r_ram[w_addr[IW+1:2]];
    end
  end
  always_ff @(posedge i_Clk)
    if (w_commit && w_we && !w_err)
      r_ram[w_addr[IW+1:2]] <= w_wdata;
endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: transaction-level model check of three DUTs (WAIT_STATES 2, 0, 1) plus directed literals
module tb_dbus_responder;
  logic        clk = 1'b0;
  logic        rstn [3];
  logic        re [3], we [3], busy [3], done [3], err [3];
  logic [31:0] addr [3], wd [3], rd [3];
  int          ws [3] = '{2, 0, 1};
  int          checks = 0, errors = 0, cyc = 0;
  bit          started [3], act [3], tre [3], twe [3], terr [3], mrd_ok [3];
  int          rem [3];
  logic [31:0] ta [3], td [3], mrd [3];
  logic [31:0] mem [int];
  bit          done_seen [3], err_at [3];
  int          done_cyc [3], acc_cyc [3], busy_n [3];
  logic [31:0] rd_at [3];
  always #5 clk = ~clk;
  dbus_responder #(.WAIT_STATES(2)) u0 (.i_Clk(clk), .i_Rstn(rstn[0]), .i_dMEM_ReadEn(re[0]),
    .i_dMEM_WriteEn(we[0]), .i_dMEM_Addr(addr[0]), .i_dMEM_Data_write(wd[0]),
    .o_dMEM_Data_read(rd[0]), .o_Busy(busy[0]), .o_Done(done[0]), .o_Error(err[0]));
  dbus_responder #(.WAIT_STATES(0)) u1 (.i_Clk(clk), .i_Rstn(rstn[1]), .i_dMEM_ReadEn(re[1]),
    .i_dMEM_WriteEn(we[1]), .i_dMEM_Addr(addr[1]), .i_dMEM_Data_write(wd[1]),
    .o_dMEM_Data_read(rd[1]), .o_Busy(busy[1]), .o_Done(done[1]), .o_Error(err[1]));
  dbus_responder #(.WAIT_STATES(1)) u2 (.i_Clk(clk), .i_Rstn(rstn[2]), .i_dMEM_ReadEn(re[2]),
    .i_dMEM_WriteEn(we[2]), .i_dMEM_Addr(addr[2]), .i_dMEM_Data_write(wd[2]),
    .o_dMEM_Data_read(rd[2]), .o_Busy(busy[2]), .o_Done(done[2]), .o_Error(err[2]));
  task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, k, cyc, got, exp);
    end
  endtask
  function automatic int key(int k, logic [31:0] a);
    return k * 8192 + int'(a >> 2);
  endfunction
  // Memory/readback effect of a finished transaction
  function automatic void commit(int k);
    if (terr[k]) begin
      if (tre[k]) begin mrd[k] = 0; mrd_ok[k] = 1; end
    end else begin
      if (twe[k]) mem[key(k, ta[k])] = td[k];
      if (tre[k]) begin
        mrd_ok[k] = mem.exists(key(k, ta[k]));
        if (mrd_ok[k]) mrd[k] = mem[key(k, ta[k])];
      end
    end
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (started[k]) begin
        chk("busy", k, 32'(busy[k]), act[k] ? 32'(rem[k] > 0) : 32'(re[k] | we[k]));
        chk("done", k, 32'(done[k]), 32'(act[k] && rem[k] == 0));
        chk("error", k, 32'(err[k]), 32'(act[k] && rem[k] == 0 && terr[k]));
        if (mrd_ok[k]) chk("rdata", k, rd[k], mrd[k]);
      end
      if (done[k] === 1'b1) begin
        done_seen[k] = 1; done_cyc[k] = cyc; rd_at[k] = rd[k]; err_at[k] = err[k];
      end
      if (busy[k] === 1'b1) busy_n[k]++;
      if (!rstn[k]) begin
        act[k] = 0; mrd[k] = 0; mrd_ok[k] = 1; started[k] = 1;
      end else if (!act[k]) begin
        if (re[k] | we[k]) begin
          act[k] = 1; rem[k] = ws[k]; acc_cyc[k] = cyc;
          ta[k] = addr[k]; td[k] = wd[k]; tre[k] = re[k]; twe[k] = we[k];
          terr[k] = (addr[k][1:0] != 0) || (addr[k] >= 32'h1000) || (re[k] && we[k]);
          if (rem[k] == 0) commit(k);
        end
      end else if (rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) commit(k);
      end else act[k] = 0;
    end
  end
  task automatic issue(int k, bit r, bit w, logic [31:0] a, logic [31:0] d);
    @(posedge clk); #1;
    re[k] = r; we[k] = w; addr[k] = a; wd[k] = d; busy_n[k] = 0; done_seen[k] = 0;
  endtask
  task automatic wait_done(int k, int lat, bit e, bit chkrd, logic [31:0] erd);
    int n = 0;
    while (!done_seen[k] && n < 20) begin @(posedge clk); n++; end
    chk("done_timeout", k, 32'(done_seen[k]), 1);
    chk("latency", k, done_cyc[k] - acc_cyc[k], lat);
    chk("busy_cycles", k, busy_n[k], lat);
    chk("err_at_done", k, 32'(err_at[k]), 32'(e));
    if (chkrd) chk("rdata_at_done", k, rd_at[k], erd);
  endtask
  task automatic txn(int k, bit r, bit w, logic [31:0] a, logic [31:0] d, int lat, bit e,
                     bit chkrd, logic [31:0] erd);
    issue(k, r, w, a, d);
    @(posedge clk); #1; re[k] = 0; we[k] = 0;
    wait_done(k, lat, e, chkrd, erd);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] v [4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    int prev, n;
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 0; re[k] = 0; we[k] = 0; addr[k] = 0; wd[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rstn[k] = 1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, 32'(busy[k]), 0);
      chk("rst_done", k, 32'(done[k]), 0);
      chk("rst_error", k, 32'(err[k]), 0);
      chk("rst_rdata", k, rd[k], 0);
    end
    txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 3, 0, 1, 32'h0);
    txn(0, 1, 0, 32'h10, 32'h0, 3, 0, 1, 32'hDEADBEEF);
    txn(1, 0, 1, 32'h10, 32'hDEADBEEF, 1, 0, 1, 32'h0);
    txn(1, 1, 0, 32'h10, 32'h0, 1, 0, 1, 32'hDEADBEEF);
    txn(0, 0, 1, 32'h0, 32'hA5A5A5A5, 3, 0, 0, 32'h0);
    txn(0, 1, 0, 32'h13, 32'h0, 3, 1, 1, 32'h0);
    txn(0, 0, 1, 32'h1000, 32'h77777777, 3, 1, 1, 32'h0);
    txn(0, 1, 1, 32'h0, 32'h12345678, 3, 1, 1, 32'h0);
    txn(0, 1, 0, 32'h0, 32'h0, 3, 0, 1, 32'hA5A5A5A5);
    txn(0, 0, 1, 32'h24, 32'h33333333, 3, 0, 0, 32'h0);
    issue(0, 0, 1, 32'h20, 32'h11111111);
    @(posedge clk); #1; addr[0] = 32'h24; wd[0] = 32'h22222222;
    @(posedge clk); #1; we[0] = 0;
    wait_done(0, 3, 0, 0, 32'h0);
    txn(0, 1, 0, 32'h20, 32'h0, 3, 0, 1, 32'h11111111);
    txn(0, 1, 0, 32'h24, 32'h0, 3, 0, 1, 32'h33333333);
    txn(0, 0, 1, 32'h30, 32'h55555555, 3, 0, 0, 32'h0);
    issue(0, 0, 1, 32'h30, 32'hAAAAAAAA);
    @(posedge clk); #1; we[0] = 0; rstn[0] = 0;
    @(posedge clk); #1; rstn[0] = 1;
    repeat (5) @(posedge clk);
    chk("no_done_after_reset", 0, 32'(done_seen[0]), 0);
    txn(0, 1, 0, 32'h30, 32'h0, 3, 0, 1, 32'h55555555);
    @(posedge clk); #1;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      re[2] = i >= 4; we[2] = i < 4; addr[2] = 32'(4 * (i % 4)); wd[2] = v[i % 4];
      busy_n[2] = 0; done_seen[2] = 0; n = 0;
      while (!done_seen[2] && n < 20) begin @(posedge clk); n++; end
      chk("b2b_done_timeout", 2, 32'(done_seen[2]), 1);
      chk("b2b_busy_cycles", 2, busy_n[2], 2);
      if (i > 0) chk("b2b_period", 2, done_cyc[2] - prev, 3);
      if (i >= 4) chk("b2b_rdata", 2, rd_at[2], v[i % 4]);
      prev = done_cyc[2];
      #1;
    end
    re[2] = 0; we[2] = 0;
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Slave/responder end of the core data bus (DBUS); services load/store requests issued by the memory-access stage.
- Contains a word-addressed data RAM, a programmable wait-state counter and a small FSM.
- Drives a busy/stall request back to the pipeline controller while an access is in flight.
- Flags illegal accesses (misaligned, out of range, simultaneous read+write) without touching memory.

Parameters:
ADDR_W, 32, byte address width of the DBUS
DATA_W, 32, data bus width (word = DATA_W/8 bytes; only 32 supported)
DEPTH, 1024, number of RAM words; legal byte addresses 0 .. DEPTH*4-1
WAIT_STATES, 2, extra wait cycles per access (0..15)

Ports:
i_Clk  in  1  system clock
i_Rstn  in  1  reset, synchronous, active-low
i_dMEM_ReadEn  in  1  load request
i_dMEM_WriteEn  in  1  store request
i_dMEM_Addr  in  ADDR_W  byte address
i_dMEM_Data_write  in  DATA_W  store data
o_dMEM_Data_read  out  DATA_W  load data (registered)
o_Busy  out  1  stall request to pipeline control
o_Done  out  1  one-cycle completion pulse
o_Error  out  1  one-cycle illegal-access pulse, coincident with o_Done

Behaviour:
- Single clock i_Clk; reset is synchronous and active-low on i_Rstn.
- Reset values:
  - state = IDLE; wait counter = 0.
  - o_dMEM_Data_read = 0; o_Done = 0; o_Error = 0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req = ReadEn | WriteEn.
  - On req: capture addr, wdata, ReadEn, WriteEn.
  - Next state: WAIT if WAIT_STATES > 0, otherwise RESP.
  - Counter loads WAIT_STATES-1.
- WAIT:
  - Counter decrements each cycle; leave for RESP when counter == 0.
  - Bus inputs ignored; captured values are used.
- RESP:
  - Lasts exactly 1 cycle; o_Done = 1 (and o_Error if illegal); next state IDLE.
  - No new request is accepted while in RESP.
- o_Busy (combinational) = (IDLE & req) | WAIT. It is 0 in RESP and 0 in IDLE without a request.
- Latency: request accepted in cycle T -> o_Done in cycle T+WAIT_STATES+1. Total o_Busy-high cycles = WAIT_STATES+1.
- Access commit, on the clock edge entering RESP:
  - Store: RAM[addr[ADDR_W-1:2]] <= wdata.
  - Load: o_dMEM_Data_read <= RAM[addr[ADDR_W-1:2]].
- Read-after-write to the same address in back-to-back transactions returns the new data.
- o_dMEM_Data_read holds the last completed load value; it is unchanged by stores and by errors, except that an erroneous load drives 0.
- Illegal access:
  - Conditions: addr[1:0] != 0, or addr >= DEPTH*4, or ReadEn & WriteEn both high at capture.
  - Response: full normal latency, o_Error = 1 with o_Done, no RAM write, load data = 0.
- Request inputs changing during WAIT have no effect.
- A request still asserted in RESP is ignored; if still asserted in the following IDLE cycle, it is accepted as a new transaction.
- Reset mid-operation (WAIT or RESP-entry not yet reached): return to IDLE, pending store not committed, no o_Done.
- Wait counter width is $clog2(WAIT_STATES+1), minimum 1 bit; no wrap is possible because the counter reloads on each accept.

Test Plan:
- Reset with WAIT_STATES=2: o_Busy=0, o_Done=0, o_Error=0, o_dMEM_Data_read=0. Store 0xDEADBEEF to 0x10 -> o_Busy high 3 cycles, o_Done in 3rd cycle after accept, o_Error=0.
- Load 0x10 immediately after that store -> o_dMEM_Data_read=0xDEADBEEF at o_Done, latency 3. Repeat with WAIT_STATES=0 -> o_Busy 1 cycle, o_Done next cycle.
- Misaligned load 0x13, out-of-range store to DEPTH*4 (0x1000), and ReadEn+WriteEn together -> each gives o_Done & o_Error; RAM word 0 unchanged; load data 0.
- Change address/data during WAIT (store 0x20 with 0x11111111, then switch inputs to 0x24 / 0x22222222) -> RAM[0x20]=0x11111111, RAM[0x24] untouched.
- Assert i_Rstn=0 in the middle of WAIT of a store to 0x30 -> FSM in IDLE, no o_Done, later load of 0x30 returns prior content.
- Back-to-back requests held continuously for 4 transactions with WAIT_STATES=1 -> exactly one o_Done per 3 cycles (2 busy + 1 RESP), addresses 0x0, 0x4, 0x8, 0xC return the values written.
